// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - DDS waveform generator with debounced wave/frequency step keys
// Phase accumulator drives a sine/square/triangle/sawtooth sample; keys step waveform and frequency.
module wave_gen #(
  parameter logic [31:0] FTW_BASE     = 32'd85899,
  parameter int          DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wave_key,
  input  logic       freq_key,
  output logic [7:0] data,
  output logic [1:0] wave_sel,
  output logic [2:0] freq_idx,
  output logic [6:0] SEG_FREQ
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  // First quadrant of round(127*sin); the other three quadrants are mirrored from it.
  localparam logic [6:0] QSINE [65] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
    7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
    7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

  logic [1:0]    keys;
  logic [1:0]    sync [2];
  logic [1:0]    armed;
  logic [1:0]    press;
  db_state_t     st   [2];
  logic [CW-1:0] cnt  [2];
  logic [31:0]   acc;

  assign keys = {freq_key, wave_key};

  function automatic logic [7:0] sine_sample(input logic [7:0] p);
    logic [6:0] idx;
    logic [6:0] amp;
    idx = {1'b0, p[5:0]};
    amp = p[6] ? QSINE[7'd64 - idx] : QSINE[idx];
    return p[7] ? (8'd128 - {1'b0, amp}) : (8'd128 + {1'b0, amp});
  endfunction

  function automatic logic [7:0] wave_sample(input logic [7:0] p, input logic [1:0] sel);
    case (sel)
      2'd0:    return sine_sample(p);
      2'd1:    return p[7] ? 8'd0 : 8'd255;
      2'd2:    return p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      default: return p;
    endcase
  endfunction

  function automatic logic [6:0] seg_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return 7'b1111001;
      3'd1:    return 7'b0100100;
      3'd2:    return 7'b0110000;
      3'd3:    return 7'b0011001;
      3'd4:    return 7'b0010010;
      3'd5:    return 7'b0000010;
      3'd6:    return 7'b1111000;
      default: return 7'b0000000;
    endcase
  endfunction

  // Synchronizers reset to "pressed" and armed stays low until a released level is seen,
  // so a key held through reset cannot register until it is let go and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        sync[i]  <= 2'b00;
        armed[i] <= 1'b0;
        st[i]    <= IDLE;
        cnt[i]   <= '0;
        press[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync[i]  <= {sync[i][0], keys[i]};
        press[i] <= 1'b0;
        if (sync[i][1]) armed[i] <= 1'b1;
        case (st[i])
          IDLE: begin
            if (!sync[i][1] && armed[i]) begin
              st[i]  <= PRESS_WAIT;
              cnt[i] <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync[i][1]) begin
              st[i] <= IDLE;
            end else if (cnt[i] == CNT_LAST) begin
              st[i]    <= HELD;
              press[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          HELD: begin
            if (sync[i][1]) begin
              st[i]  <= RELEASE_WAIT;
              cnt[i] <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (!sync[i][1]) begin
              st[i] <= HELD;
            end else if (cnt[i] == CNT_LAST) begin
              st[i] <= IDLE;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      wave_sel <= '0;
      freq_idx <= '0;
      data     <= 8'd128;
      SEG_FREQ <= 7'b1111001;
    end else begin
      acc      <= acc + (FTW_BASE << freq_idx);
      wave_sel <= wave_sel + {1'b0, press[0]};
      freq_idx <= freq_idx + {2'b00, press[1]};
      data     <= wave_sample(acc[31:24], wave_sel);
      SEG_FREQ <= seg_code(freq_idx);
    end
  end

endmodule
